// File: rtl/vga_bus_pkg.sv
// Shared constants and state encoding for the VGA frame-buffer bus master.
// Peripheral register map and screen limits live here so every stage agrees.
package vga_bus_pkg;

  localparam logic [7:0] X_MAX     = 8'd159;
  localparam logic [6:0] Y_MAX     = 7'd119;
  localparam logic [7:0] ADDR_Y    = 8'hB0;
  localparam logic [7:0] ADDR_X    = 8'hB1;
  localparam logic [7:0] ADDR_DATA = 8'hB2;

  typedef enum logic [2:0] {
    IDLE,
    WR_Y,
    WR_X,
    WR_D,
    FIN
  } state_t;

endpackage

// File: rtl/vga_rect_filler_if.sv
// Command handshake plus the write bus toward the arbiter.
// The master modport is the filler itself; slave is whoever drives commands and grants.
interface vga_rect_filler_if;

  logic       CMD_VALID;
  logic       CMD_READY;
  logic [7:0] X0;
  logic [7:0] X1;
  logic [6:0] Y0;
  logic [6:0] Y1;
  logic       COLOUR;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;
  logic       BUS_WE;
  logic       DONE;

  modport master (
    input  CMD_VALID, X0, X1, Y0, Y1, COLOUR, BUS_GNT,
    output CMD_READY, BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, DONE
  );

  modport slave (
    output CMD_VALID, X0, X1, Y0, Y1, COLOUR, BUS_GNT,
    input  CMD_READY, BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, DONE
  );

endinterface

// File: rtl/vga_xy_counter.sv
// Pixel position counters for one rectangle, with the latched bounds they run between.
// row_end/last are compared before any increment, so the counters never wrap.
module vga_xy_counter
  import vga_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] x0_in,
  input  logic [7:0] x1_in,
  input  logic [6:0] y0_in,
  input  logic [6:0] y1_in,
  input  logic       x_step,
  input  logic       y_step,
  output logic [7:0] cx,
  output logic [6:0] cy,
  output logic       row_end,
  output logic       last
);

  logic [7:0] x0_reg;
  logic [7:0] x1_reg;
  logic [6:0] y1_reg;
  logic [7:0] cx_reg;
  logic [6:0] cy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_reg <= '0;
      x1_reg <= '0;
      y1_reg <= '0;
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (load) begin
      x0_reg <= x0_in;
      x1_reg <= x1_in;
      y1_reg <= y1_in;
      cx_reg <= x0_in;
      cy_reg <= y0_in;
    end else if (y_step) begin
      cx_reg <= x0_reg;
      cy_reg <= cy_reg + 7'd1;
    end else if (x_step) begin
      cx_reg <= cx_reg + 8'd1;
    end
  end

  assign cx      = cx_reg;
  assign cy      = cy_reg;
  assign row_end = (cx_reg == x1_reg);
  assign last    = row_end && (cy_reg == y1_reg);

endmodule

// File: rtl/vga_rect_filler.sv
// Turns one rectangle-fill command into the Y / X / pixel register-write sequence
// of the frame-buffer peripheral, stalling on the arbiter grant.
module vga_rect_filler
  import vga_bus_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  vga_rect_filler_if.master bus
);

  state_t     state_reg;
  logic       req_reg;
  logic       we_reg;
  logic       done_reg;
  logic [7:0] addr_reg;
  logic [7:0] data_reg;
  logic       colour_reg;

  logic [7:0] x1_clamped;
  logic [6:0] y1_clamped;
  logic       empty_cmd;
  logic       accept;
  logic       d_done;
  logic       x_step;
  logic       y_step;
  logic [7:0] cx;
  logic [6:0] cy;
  logic       row_end;
  logic       last;

  assign x1_clamped = (bus.X1 > X_MAX) ? X_MAX : bus.X1;
  assign y1_clamped = (bus.Y1 > Y_MAX) ? Y_MAX : bus.Y1;
  // X0/Y0 beyond the screen are caught by comparing against the clamped upper bound.
  assign empty_cmd  = (bus.X0 > x1_clamped) || (bus.Y0 > y1_clamped);

  assign accept = (state_reg == IDLE) && bus.CMD_VALID;
  assign d_done = (state_reg == WR_D) && bus.BUS_GNT;
  assign x_step = d_done && !row_end;
  assign y_step = d_done && row_end && !last;

  vga_xy_counter u_xy (
    .clk     (CLK),
    .rst     (RESET),
    .load    (accept),
    .x0_in   (bus.X0),
    .x1_in   (x1_clamped),
    .y0_in   (bus.Y0),
    .y1_in   (y1_clamped),
    .x_step  (x_step),
    .y_step  (y_step),
    .cx      (cx),
    .cy      (cy),
    .row_end (row_end),
    .last    (last)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg  <= IDLE;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      done_reg   <= 1'b0;
      addr_reg   <= 8'h00;
      data_reg   <= 8'h00;
      colour_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.CMD_VALID) begin
            colour_reg <= bus.COLOUR;
            if (empty_cmd) begin
              state_reg <= FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= WR_Y;
              req_reg   <= 1'b1;
              we_reg    <= 1'b1;
              addr_reg  <= ADDR_Y;
              data_reg  <= {1'b0, bus.Y0};
            end
          end
        end
        WR_Y: begin
          if (bus.BUS_GNT) begin
            state_reg <= WR_X;
            addr_reg  <= ADDR_X;
            data_reg  <= cx;
          end
        end
        WR_X: begin
          if (bus.BUS_GNT) begin
            state_reg <= WR_D;
            addr_reg  <= ADDR_DATA;
            data_reg  <= {7'b0, colour_reg};
          end
        end
        WR_D: begin
          // Next write is presented with the post-increment position, so the
          // counter value is bumped here in parallel with the counter itself.
          if (bus.BUS_GNT) begin
            if (!row_end) begin
              state_reg <= WR_X;
              addr_reg  <= ADDR_X;
              data_reg  <= cx + 8'd1;
            end else if (!last) begin
              state_reg <= WR_Y;
              addr_reg  <= ADDR_Y;
              data_reg  <= {1'b0, cy + 7'd1};
            end else begin
              state_reg <= FIN;
              req_reg   <= 1'b0;
              we_reg    <= 1'b0;
              addr_reg  <= 8'h00;
              data_reg  <= 8'h00;
              done_reg  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.CMD_READY = (state_reg == IDLE);
  assign bus.BUS_REQ   = req_reg;
  assign bus.BUS_WE    = we_reg;
  assign bus.BUS_ADDR  = addr_reg;
  assign bus.BUS_DATA  = data_reg;
  assign bus.DONE      = done_reg;

endmodule

// File: doc/vga_rect_filler.md
# vga_rect_filler

Bus-master stage upstream of the VGA frame-buffer I/O peripheral. Accepts one rectangle-fill command at a time and converts it into the peripheral's register-write sequence: Y at 0xB0, X at 0xB1, pixel data at 0xB2, with one pixel written per data write. Lets the CPU clear the screen or draw blocks without issuing thousands of bus writes itself. Its bus outputs go through the existing bus arbiter, which forwards them to the peripheral only while `BUS_GNT` is high.

## Interface
- `X_MAX`, 159: last valid X coordinate (8-bit).
- `Y_MAX`, 119: last valid Y coordinate (7-bit).
- `ADDR_Y`, 8'hB0: peripheral Y register address.
- `ADDR_X`, 8'hB1: peripheral X register address.
- `ADDR_DATA`, 8'hB2: peripheral pixel-data register address.

- `CLK`  in  1  system clock; the only clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `CMD_VALID`  in  1  command present.
- `CMD_READY`  out  1  block idle; a command is accepted when `CMD_VALID & CMD_READY`.
- `X0`, `X1`  in  8  inclusive X bounds.
- `Y0`, `Y1`  in  7  inclusive Y bounds.
- `COLOUR`  in  1  pixel value to write.
- `BUS_REQ`  out  1  bus wanted; high from acceptance until the last write completes.
- `BUS_GNT`  in  1  arbiter grant.
- `BUS_ADDR`  out  8  write address.
- `BUS_DATA`  out  8  write data.
- `BUS_WE`  out  1  write strobe.
- `DONE`  out  1  one-cycle pulse when a command finishes.

## Operation
- FSM states: `IDLE`, `WR_Y`, `WR_X`, `WR_D`, `FIN`.
- Only `IDLE` asserts `CMD_READY`.
- On acceptance:
  - Latch the command fields into registers.
  - Clamp `X1` to `X_MAX` and `Y1` to `Y_MAX`.
  - Load the X counter `cx = X0` and the Y counter `cy = Y0`.
- Empty command: if `X0 > X1`, `Y0 > Y1`, `X0 > X_MAX` or `Y0 > Y_MAX` (after clamping), go directly to `FIN`. No bus writes are issued.
- Otherwise go to `WR_Y`. Each write state presents one write:
  - `WR_Y`: `ADDR_Y`, data `{1'b0, cy}`.
  - `WR_X`: `ADDR_X`, data `cx`.
  - `WR_D`: `ADDR_DATA`, data `{7'b0, COLOUR}`.
- A write completes in a cycle where `BUS_WE & BUS_GNT`. While `BUS_GNT` is low, address, data and strobe hold unchanged and the state does not advance.
- Transitions on a completed write:
  - `WR_Y` → `WR_X`.
  - `WR_X` → `WR_D`.
  - `WR_D`, `cx < X1`: `cx++`, go to `WR_X`.
  - `WR_D`, `cx == X1`, `cy < Y1`: `cx = X0`, `cy++`, go to `WR_Y`.
  - `WR_D`, `cx == X1`, `cy == Y1`: go to `FIN`.
- `FIN`: pulse `DONE` for one cycle, drop `BUS_REQ`, return to `IDLE`.
- Write count per command: H + 2·W·H. A full screen takes 120 + 38400 = 38520 writes.
- Counter widths: `cx` is 8-bit and `cy` is 7-bit. Comparisons are done before the increment, so counters never wrap.
- `CMD_VALID` while busy is ignored; the upstream must hold it until `CMD_READY`.

## Timing
- All outputs are registered except `CMD_READY`, which decodes `IDLE`.
- Reset values:
  - `BUS_REQ`, `BUS_WE`, `DONE`: 0.
  - `BUS_ADDR`, `BUS_DATA`: 8'h00.
  - `CMD_READY`: 1.
  - State: `IDLE`; counters: 0.
- Acceptance in cycle 0 → `BUS_REQ` and the first `BUS_WE` (Y write) in cycle 1.
- With `BUS_GNT` held high, one write completes per cycle.
- `DONE` rises in the cycle after the last completed write. `CMD_READY` is high in the cycle after `DONE`, so a new command can be accepted then.
- Empty command: `DONE` rises in cycle 1.
- When `BUS_WE` is 0, `BUS_ADDR` and `BUS_DATA` are 8'h00.
- Reset mid-command: all outputs return to their reset values immediately (asynchronous). The command is dropped with no `DONE`. Pixels already written remain in the frame buffer.

## Structure
- Shared package `vga_bus_pkg`:
  - `ADDR_Y`, `ADDR_X`, `ADDR_DATA` default constants.
  - `X_MAX`, `Y_MAX`.
  - State enum.
- Optional sub-module `vga_xy_counter`: holds `cx`/`cy`, loads X0/Y0 and outputs `row_end`/`last` flags. The FSM stays in `vga_rect_filler`.

## Test plan
- Single pixel (X0=X1=5, Y0=Y1=3, COLOUR=1), GNT=1 → writes (B0,03), (B1,05), (B2,01) in cycles 1–3; `DONE` in cycle 4; `CMD_READY` high in cycle 5.
- 2×2 at (10,20), COLOUR=0 → 10 writes: B0=14, B1=0A, B2=00, B1=0B, B2=00, B0=15, B1=0A, B2=00, B1=0B, B2=00; `DONE` once.
- Same single pixel with GNT low in cycles 2–4 → (B1,05) held stable for 4 cycles with no advance; `DONE` in cycle 7.
- X0=9, X1=3 → no `BUS_WE`; `DONE` in cycle 1. Separately X0=158, X1=255, Y0=Y1=119 → X writes 9E, 9F only.
- Full screen, GNT=1 → exactly 38520 writes; last write is (B2,COLOUR) at X=9F, Y=77.
- RESET pulse during the `WR_X` of a 4×4 command → outputs zero immediately, no `DONE`; a new command is accepted normally after release.
